alu_add16_arbiter: RTL and testbench

//  Round-robin arbiter and scheduler sharing one ALUAdd16 instance among NREQ requesters.
//  - Each requester presents an operand pair (a, b) with a valid/ready handshake.
//  - One grant is issued per cycle. The granted pair drives the shared adder.
//  - The 16-bit sum, overflow flag and requester id are captured in a single output register.
//  - The response is returned through a valid/ready handshake.
//  - Sits between the decode/issue stages and the ALU adder datapath.

---
 rtl/alu_add16_arbiter.sv | 111 +++++++++++
 tb/tb_alu_add16_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_add16_arbiter.sv
// alu_add16_arbiter: round-robin sharing of one 16-bit adder among NREQ requesters.
// Define ALU_ARB_SAT_EN to saturate rsp_out to 16'hFFFF when the adder overflows.
module alu_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
endmodule

module alu_add16_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_out,
    output logic                 rsp_overflow,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          busy_cnt
);
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gidx;
    logic [IDW:0]    s;
    logic            found;
    logic            can_accept;
    logic            grant;
    logic [NREQ-1:0] onehot;
    logic [15:0]     a_sel;
    logic [15:0]     b_sel;
    logic [15:0]     sum;
    logic [15:0]     sum_fin;
    logic            carry;

    assign can_accept = !rsp_valid || rsp_ready;
    assign grant      = found && can_accept && !rst;
    assign req_ready  = grant ? onehot : '0;

    // Scan ptr, ptr+1, ... wrapping at NREQ; first valid requester wins.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        s     = '0;
        for (int k = 0; k < NREQ; k++) begin
            s = {1'b0, ptr} + (IDW+1)'(k);
            if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
            if (!found && req_valid[s[IDW-1:0]]) begin
                found = 1'b1;
                gidx  = s[IDW-1:0];
            end
        end
    end

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IDW'(i)) begin
                a_sel     = req_a[16*i +: 16];
                b_sel     = req_b[16*i +: 16];
                onehot[i] = 1'b1;
            end
        end
    end

    alu_add16 u_add (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

`ifdef ALU_ARB_SAT_EN
    assign sum_fin = carry ? 16'hFFFF : sum;
`else
    assign sum_fin = sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            rsp_valid    <= 1'b0;
            rsp_out      <= '0;
            rsp_overflow <= 1'b0;
            rsp_id       <= '0;
            busy_cnt     <= '0;
        end else begin
            if (grant) begin
                rsp_valid    <= 1'b1;
                rsp_out      <= sum_fin;
                rsp_overflow <= carry;
                rsp_id       <= gidx;
                ptr          <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (|req_valid && !can_accept && busy_cnt != 16'hFFFF)
                busy_cnt <= busy_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_alu_add16_arbiter.sv
// tb_alu_add16_arbiter: directed vectors for the round-robin shared-adder arbiter.
module tb_alu_add16_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_out;
    logic        rsp_overflow;
    logic [1:0]  rsp_id;
    logic [15:0] busy_cnt;
    int          nvec = 0;
    int          nerr = 0;

`ifdef ALU_ARB_SAT_EN
    localparam logic [15:0] EXP_OVF2 = 16'hFFFF;
    localparam logic [15:0] EXP_OVF1 = 16'hFFFF;
`else
    localparam logic [15:0] EXP_OVF2 = 16'h0001;
    localparam logic [15:0] EXP_OVF1 = 16'h0000;
`endif

    always #5 clk = ~clk;

    alu_add16_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_out      (rsp_out),
        .rsp_overflow (rsp_overflow),
        .rsp_id       (rsp_id),
        .busy_cnt     (busy_cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1; req_a = '0; req_b = '0;
        cyc();
        cyc();
        @(negedge clk);
        nvec++;
        if (req_ready !== 4'b0000) begin nerr++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        nvec++;
        if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        nvec++;
        if (busy_cnt !== 16'd0) begin nerr++; $display("FAIL reset_busy: got %h want 0000", busy_cnt); end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (req_ready !== 4'b0001) begin nerr++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
        cyc();
        req_valid = 4'h0;
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            nerr++; $display("FAIL reset_first_rsp: got valid=%b id=%0d want valid=1 id=0", rsp_valid, rsp_id);
        end
        cyc();
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL reset_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_single_op();
        cyc();
        req_a[15:0] = 16'h1234; req_b[15:0] = 16'h0FF0; req_valid = 4'b0001;
        @(negedge clk);
        nvec++;
        if (req_ready !== 4'b0001) begin nerr++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        cyc();
        req_valid = 4'b0000;
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_out !== 16'h2224 || rsp_overflow !== 1'b0 || rsp_id !== 2'd0) begin
            nerr++; $display("FAIL single_rsp: got v=%b out=%h ovf=%b id=%0d want v=1 out=2224 ovf=0 id=0",
                             rsp_valid, rsp_out, rsp_overflow, rsp_id);
        end
    endtask

    task automatic test_overflow();
        cyc();
        req_a[47:32] = 16'hFFFF; req_b[47:32] = 16'h0002; req_valid = 4'b0100;
        @(negedge clk);
        nvec++;
        if (req_ready !== 4'b0100) begin nerr++; $display("FAIL ovf2_ready: got %b want 0100", req_ready); end
        cyc();
        req_a[63:48] = 16'hFFFF; req_b[63:48] = 16'h0001; req_valid = 4'b1000;
        @(negedge clk);
        nvec++;
        if (rsp_out !== EXP_OVF2 || rsp_overflow !== 1'b1 || rsp_id !== 2'd2) begin
            nerr++; $display("FAIL ovf2_rsp: got out=%h ovf=%b id=%0d want out=%h ovf=1 id=2",
                             rsp_out, rsp_overflow, rsp_id, EXP_OVF2);
        end
        nvec++;
        if (req_ready !== 4'b1000) begin nerr++; $display("FAIL ovf3_ready: got %b want 1000", req_ready); end
        cyc();
        req_valid = 4'b0000;
        @(negedge clk);
        nvec++;
        if (rsp_out !== EXP_OVF1 || rsp_overflow !== 1'b1 || rsp_id !== 2'd3) begin
            nerr++; $display("FAIL ovf3_rsp: got out=%h ovf=%b id=%0d want out=%h ovf=1 id=3",
                             rsp_out, rsp_overflow, rsp_id, EXP_OVF1);
        end
    endtask

    task automatic test_fairness();
        logic [15:0] exp_sum [4] = '{16'h1101, 16'h2203, 16'h3305, 16'h4407};
        logic [3:0]  exp_rdy;
        cyc();
        req_a = {16'h4003, 16'h3002, 16'h2001, 16'h1000};
        req_b = {16'h0404, 16'h0303, 16'h0202, 16'h0101};
        req_valid = 4'hF;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            exp_rdy = 4'b0001 << (j % 4);
            nvec++;
            if (req_ready !== exp_rdy) begin nerr++; $display("FAIL fair_ready_%0d: got %b want %b", j, req_ready, exp_rdy); end
            if (j > 0) begin
                nvec++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((j-1) % 4) || rsp_out !== exp_sum[(j-1) % 4]) begin
                    nerr++; $display("FAIL fair_rsp_%0d: got v=%b id=%0d out=%h want v=1 id=%0d out=%h",
                                     j, rsp_valid, rsp_id, rsp_out, (j-1) % 4, exp_sum[(j-1) % 4]);
                end
            end
            cyc();
        end
        req_valid = 4'h0;
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_out !== 16'h2203) begin
            nerr++; $display("FAIL fair_rsp_last: got v=%b id=%0d out=%h want v=1 id=1 out=2203", rsp_valid, rsp_id, rsp_out);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        req_a[31:16] = 16'h0010; req_b[31:16] = 16'h0020; req_valid = 4'b0010; rsp_ready = 1'b0;
        @(negedge clk);
        nvec++;
        if (req_ready !== 4'b0010) begin nerr++; $display("FAIL bp_first_ready: got %b want 0010", req_ready); end
        cyc();
        req_a[31:16] = 16'h0100; req_b[31:16] = 16'h0200;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nvec++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_out !== 16'h0030 || rsp_id !== 2'd1) begin
                nerr++; $display("FAIL bp_stall_%0d: got rdy=%b v=%b out=%h id=%0d want rdy=0000 v=1 out=0030 id=1",
                                 k, req_ready, rsp_valid, rsp_out, rsp_id);
            end
            nvec++;
            if (busy_cnt !== 16'(k)) begin nerr++; $display("FAIL bp_busy_%0d: got %0d want %0d", k, busy_cnt, k); end
            cyc();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        nvec++;
        if (req_ready !== 4'b0010 || busy_cnt !== 16'd3) begin
            nerr++; $display("FAIL bp_release: got rdy=%b busy=%0d want rdy=0010 busy=3", req_ready, busy_cnt);
        end
        cyc();
        req_valid = 4'b0000;
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_out !== 16'h0300 || rsp_id !== 2'd1) begin
            nerr++; $display("FAIL bp_refill: got v=%b out=%h id=%0d want v=1 out=0300 id=1", rsp_valid, rsp_out, rsp_id);
        end
        cyc();
    endtask

    task automatic test_reset_mid_op();
        req_a[47:32] = 16'h5555; req_b[47:32] = 16'h1111; req_valid = 4'b0100; rsp_ready = 1'b0;
        @(negedge clk);
        nvec++;
        if (req_ready !== 4'b0100) begin nerr++; $display("FAIL rmid_ready: got %b want 0100", req_ready); end
        cyc();
        req_valid = 4'b1010; rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_out !== 16'h6666 || req_ready !== 4'b0000) begin
            nerr++; $display("FAIL rmid_pre: got v=%b out=%h rdy=%b want v=1 out=6666 rdy=0000", rsp_valid, rsp_out, req_ready);
        end
        cyc();
        rst = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b0 || rsp_out !== 16'h0000 || busy_cnt !== 16'd0) begin
            nerr++; $display("FAIL rmid_post: got v=%b out=%h busy=%0d want v=0 out=0000 busy=0", rsp_valid, rsp_out, busy_cnt);
        end
        nvec++;
        if (req_ready !== 4'b0010) begin nerr++; $display("FAIL rmid_ptr: got %b want 0010", req_ready); end
        cyc();
        req_valid = 4'b0000;
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_out !== 16'h0300) begin
            nerr++; $display("FAIL rmid_rsp: got v=%b id=%0d out=%h want v=1 id=1 out=0300", rsp_valid, rsp_id, rsp_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_overflow();
        test_fairness();
        test_backpressure();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
